// File: rtl/rom_load_sequencer_if.sv
// ============================================================================
// Module      : rom_load_sequencer_if
// Description : HPS ioctl download bus and the decoded per-ROM write bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rom_load_sequencer_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [16:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [16:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr_prog;
    logic        dn_wr_char;
    logic        dn_wr_sync;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_data,
        input  dn_addr, dn_data, dn_wr_prog, dn_wr_char, dn_wr_sync
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_data,
        output dn_addr, dn_data, dn_wr_prog, dn_wr_char, dn_wr_sync
    );
endinterface

`default_nettype wire

// File: rtl/rom_load_sequencer.sv
// ============================================================================
// Module      : rom_load_sequencer
// Description : Decodes HPS ROM download writes into per-ROM strobes and holds
//               the game core in reset during and after a download.
//               Optional DL_CHECKSUM_EN adds a per-download byte checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_load_sequencer #(
    parameter int unsigned PROG_SIZE   = 4096,
    parameter int unsigned CHAR_SIZE   = 512,
    parameter int unsigned SYNC_SIZE   = 256,
    parameter int unsigned HOLD_CYCLES = 1024
) (
    input  wire                         clk_sys,
    input  wire                         reset,
    input  wire                         user_reset,
    rom_load_sequencer_if.slave         io,
    output logic                        core_reset_n,
    output logic                        loaded,
`ifdef DL_CHECKSUM_EN
    output logic [7:0]                  dl_sum,
    output logic                        sum_valid,
`endif
    output logic                        overflow
);

    localparam int unsigned c_hold_w = $clog2(HOLD_CYCLES + 1);
    localparam logic [c_hold_w-1:0] c_hold_init = c_hold_w'(HOLD_CYCLES);
    localparam logic [17:0] c_prog_end = 18'(PROG_SIZE);
    localparam logic [17:0] c_char_end = 18'(PROG_SIZE + CHAR_SIZE);
    localparam logic [17:0] c_sync_end = 18'(PROG_SIZE + CHAR_SIZE + SYNC_SIZE);

    localparam logic [1:0] c_st_run  = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [c_hold_w-1:0] hold_cnt_q, hold_cnt_d;
    logic                core_reset_n_q, core_reset_n_d;
    logic [16:0]         dn_addr_q, dn_addr_d;
    logic [7:0]          dn_data_q, dn_data_d;
    logic                dn_wr_prog_q, dn_wr_prog_d;
    logic                dn_wr_char_q, dn_wr_char_d;
    logic                dn_wr_sync_q, dn_wr_sync_d;
    logic [16:0]         byte_cnt_q, byte_cnt_d;
    logic                loaded_q, loaded_d;
    logic                overflow_q, overflow_d;
`ifdef DL_CHECKSUM_EN
    logic [7:0]          dl_sum_q, dl_sum_d;
    logic                sum_valid_q, sum_valid_d;
`endif

    logic [17:0]         w_addr;
    logic                w_wr_act;
    logic                w_entry;
    logic                w_exit;
    logic                w_in_range;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q        <= c_st_hold;
            hold_cnt_q     <= c_hold_init;
            core_reset_n_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            core_reset_n_q <= core_reset_n_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // Download takes priority over user reset in both RUN and HOLD.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            c_st_run: begin
                if (io.ioctl_download) begin
                    state_d = c_st_load;
                end else if (user_reset) begin
                    state_d    = c_st_hold;
                    hold_cnt_d = c_hold_init;
                end
            end
            c_st_load: begin
                if (!io.ioctl_download) begin
                    state_d    = c_st_hold;
                    hold_cnt_d = c_hold_init;
                end
            end
            c_st_hold: begin
                if (io.ioctl_download) begin
                    state_d = c_st_load;
                end else if (user_reset) begin
                    hold_cnt_d = c_hold_init;
                end else begin
                    hold_cnt_d = hold_cnt_q - c_hold_w'(1);
                    if (hold_cnt_q == c_hold_w'(1)) begin
                        state_d = c_st_run;
                    end
                end
            end
            default: begin
                state_d    = c_st_hold;
                hold_cnt_d = c_hold_init;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        core_reset_n_d = (state_d == c_st_run);
    end

    // ---------------- Download decode ----------------
    assign w_addr   = {1'b0, io.ioctl_addr};
    assign w_wr_act = (state_q == c_st_load) && io.ioctl_wr;
    assign w_entry  = (state_q != c_st_load) && (state_d == c_st_load);
    assign w_exit   = (state_q == c_st_load) && (state_d != c_st_load);

    always_comb begin
        dn_addr_d    = dn_addr_q;
        dn_data_d    = dn_data_q;
        dn_wr_prog_d = 1'b0;
        dn_wr_char_d = 1'b0;
        dn_wr_sync_d = 1'b0;
        byte_cnt_d   = byte_cnt_q;
        loaded_d     = loaded_q;
        overflow_d   = overflow_q;
        w_in_range   = 1'b0;
`ifdef DL_CHECKSUM_EN
        dl_sum_d     = dl_sum_q;
        sum_valid_d  = sum_valid_q;
`endif
        if (w_entry) begin
            byte_cnt_d  = '0;
            loaded_d    = 1'b0;
            overflow_d  = 1'b0;
`ifdef DL_CHECKSUM_EN
            dl_sum_d    = '0;
            sum_valid_d = 1'b0;
`endif
        end
        if (w_wr_act) begin
            if (w_addr < c_prog_end) begin
                dn_wr_prog_d = 1'b1;
                dn_addr_d    = io.ioctl_addr;
                w_in_range   = 1'b1;
            end else if (w_addr < c_char_end) begin
                dn_wr_char_d = 1'b1;
                dn_addr_d    = 17'(w_addr - c_prog_end);
                w_in_range   = 1'b1;
            end else if (w_addr < c_sync_end) begin
                dn_wr_sync_d = 1'b1;
                dn_addr_d    = 17'(w_addr - c_char_end);
                w_in_range   = 1'b1;
            end else begin
                overflow_d   = 1'b1;
            end
            if (w_in_range) begin
                dn_data_d = io.ioctl_data;
                if (byte_cnt_q != '1) begin
                    byte_cnt_d = byte_cnt_q + 17'd1;
                end
`ifdef DL_CHECKSUM_EN
                dl_sum_d = dl_sum_q + io.ioctl_data;
`endif
            end
        end
        // Completeness uses the count before any write on the falling edge.
        if (w_exit) begin
            loaded_d = ({1'b0, byte_cnt_q} >= c_sync_end);
`ifdef DL_CHECKSUM_EN
            sum_valid_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            dn_wr_prog_q <= 1'b0;
            dn_wr_char_q <= 1'b0;
            dn_wr_sync_q <= 1'b0;
            byte_cnt_q   <= '0;
            loaded_q     <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef DL_CHECKSUM_EN
            dl_sum_q     <= '0;
            sum_valid_q  <= 1'b0;
`endif
        end else begin
            dn_addr_q    <= dn_addr_d;
            dn_data_q    <= dn_data_d;
            dn_wr_prog_q <= dn_wr_prog_d;
            dn_wr_char_q <= dn_wr_char_d;
            dn_wr_sync_q <= dn_wr_sync_d;
            byte_cnt_q   <= byte_cnt_d;
            loaded_q     <= loaded_d;
            overflow_q   <= overflow_d;
`ifdef DL_CHECKSUM_EN
            dl_sum_q     <= dl_sum_d;
            sum_valid_q  <= sum_valid_d;
`endif
        end
    end

    assign io.dn_addr    = dn_addr_q;
    assign io.dn_data    = dn_data_q;
    assign io.dn_wr_prog = dn_wr_prog_q;
    assign io.dn_wr_char = dn_wr_char_q;
    assign io.dn_wr_sync = dn_wr_sync_q;
    assign core_reset_n  = core_reset_n_q;
    assign loaded        = loaded_q;
    assign overflow      = overflow_q;
`ifdef DL_CHECKSUM_EN
    assign dl_sum        = dl_sum_q;
    assign sum_valid     = sum_valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rom_load_sequencer.sv
// ============================================================================
// Module      : tb_rom_load_sequencer
// Description : Directed, table-driven self-checking bench for rom_load_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_load_sequencer;

    logic clk_sys = 1'b0;
    logic reset;
    logic user_reset;
    logic core_reset_n;
    logic loaded;
    logic overflow;
`ifdef DL_CHECKSUM_EN
    logic [7:0] dl_sum;
    logic       sum_valid;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rom_load_sequencer_if bus ();

    rom_load_sequencer dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .user_reset   (user_reset),
        .io           (bus),
        .core_reset_n (core_reset_n),
        .loaded       (loaded),
`ifdef DL_CHECKSUM_EN
        .dl_sum       (dl_sum),
        .sum_valid    (sum_valid),
`endif
        .overflow     (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        logic [2:0]  exp_stb;   // {prog, char, sync}
        logic [16:0] exp_addr;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [2:0] stb();
        return {bus.dn_wr_prog, bus.dn_wr_char, bus.dn_wr_sync};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_prog;
        int n_char;
        int n_sync;

        vecs[0] = '{17'h00000, 8'hA5, 3'b100, 17'h00000, 1'b0};
        vecs[1] = '{17'h00FFF, 8'h3C, 3'b100, 17'h00FFF, 1'b0};
        vecs[2] = '{17'h01000, 8'h11, 3'b010, 17'h00000, 1'b0};
        vecs[3] = '{17'h01005, 8'h22, 3'b010, 17'h00005, 1'b0};
        vecs[4] = '{17'h011FF, 8'h33, 3'b010, 17'h001FF, 1'b0};
        vecs[5] = '{17'h01200, 8'h44, 3'b001, 17'h00000, 1'b0};
        vecs[6] = '{17'h012FF, 8'h55, 3'b001, 17'h000FF, 1'b0};
        vecs[7] = '{17'h01300, 8'h66, 3'b000, 17'h00000, 1'b1};
        vecs[8] = '{17'h1FFFF, 8'h77, 3'b000, 17'h00000, 1'b1};

        reset              = 1'b1;
        user_reset         = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_data     = '0;
        #1;
        check("reset core_reset_n", {31'd0, core_reset_n}, 0);
        check("reset strobes", {29'd0, stb()}, 0);
        check("reset dn_addr", {15'd0, bus.dn_addr}, 0);
        check("reset loaded", {31'd0, loaded}, 0);
        check("reset overflow", {31'd0, overflow}, 0);
`ifdef DL_CHECKSUM_EN
        check("reset dl_sum", {24'd0, dl_sum}, 0);
        check("reset sum_valid", {31'd0, sum_valid}, 0);
`endif
        tick();
        tick();
        reset = 1'b0;

        // Power-up hold: 1024 edges low, then high.
        repeat (1023) tick();
        check("powerup core_reset_n at 1023", {31'd0, core_reset_n}, 0);
        tick();
        check("powerup core_reset_n at 1024", {31'd0, core_reset_n}, 1);

        // user_reset from RUN, then re-pulsed when the hold count is at 10.
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        check("user_reset from RUN", {31'd0, core_reset_n}, 0);
        repeat (1014) tick();
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        repeat (1023) tick();
        check("user_reset reload at 1023", {31'd0, core_reset_n}, 0);
        tick();
        check("user_reset reload at 1024", {31'd0, core_reset_n}, 1);

        // Download rises in RUN with a write on the same edge: write ignored.
        bus.ioctl_download = 1'b1;
        bus.ioctl_wr       = 1'b1;
        bus.ioctl_addr     = 17'h00000;
        bus.ioctl_data     = 8'h99;
        tick();
        bus.ioctl_wr = 1'b0;
        check("download in RUN core_reset_n", {31'd0, core_reset_n}, 0);
        check("write on download rise", {29'd0, stb()}, 0);

        for (int i = 0; i < 9; i++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = vecs[i].addr;
            bus.ioctl_data = vecs[i].data;
            tick();
            bus.ioctl_wr = 1'b0;
            check($sformatf("vec%0d strobes", i), {29'd0, stb()}, {29'd0, vecs[i].exp_stb});
            if (vecs[i].exp_stb != 3'b000) begin
                check($sformatf("vec%0d dn_addr", i), {15'd0, bus.dn_addr}, {15'd0, vecs[i].exp_addr});
                check($sformatf("vec%0d dn_data", i), {24'd0, bus.dn_data}, {24'd0, vecs[i].data});
            end
            check($sformatf("vec%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
            tick();
            check($sformatf("vec%0d strobe one-cycle", i), {29'd0, stb()}, 0);
        end

        // Write on the edge download falls is still decoded; short load not complete.
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b1;
        bus.ioctl_addr     = 17'h00010;
        bus.ioctl_data     = 8'h77;
        tick();
        bus.ioctl_wr = 1'b0;
        check("fall-edge write strobes", {29'd0, stb()}, 32'h4);
        check("fall-edge write dn_addr", {15'd0, bus.dn_addr}, 32'h10);
        check("short load loaded", {31'd0, loaded}, 0);
        check("short load overflow sticky", {31'd0, overflow}, 1);

        // Write in HOLD with download low: ignored.
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 17'h00001;
        tick();
        bus.ioctl_wr = 1'b0;
        check("write outside LOAD", {29'd0, stb()}, 0);

        // Full contiguous download.
        bus.ioctl_download = 1'b1;
        tick();
        check("LOAD entry clears overflow", {31'd0, overflow}, 0);
        n_prog = 0;
        n_char = 0;
        n_sync = 0;
        for (int i = 0; i < 4864; i++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = 17'(i);
            bus.ioctl_data = 8'(i);
            tick();
            if (bus.dn_wr_prog) n_prog++;
            if (bus.dn_wr_char) n_char++;
            if (bus.dn_wr_sync) n_sync++;
            if (i == 32'h1005) begin
                check("char 0x1005 strobe", {29'd0, stb()}, 32'h2);
                check("char 0x1005 dn_addr", {15'd0, bus.dn_addr}, 32'h5);
            end
        end
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        tick();
        check("full prog strobes", n_prog, 4096);
        check("full char strobes", n_char, 512);
        check("full sync strobes", n_sync, 256);
        check("full loaded", {31'd0, loaded}, 1);
        check("full overflow", {31'd0, overflow}, 0);
`ifdef DL_CHECKSUM_EN
        check("full dl_sum", {24'd0, dl_sum}, 32'h80);
        check("full sum_valid", {31'd0, sum_valid}, 1);
`endif

        // Async reset in the middle of a load.
        bus.ioctl_download = 1'b1;
        tick();
        check("reload entry clears loaded", {31'd0, loaded}, 0);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 17'h00020;
        tick();
        check("pre-reset strobe", {29'd0, stb()}, 32'h4);
        reset = 1'b1;
        #1;
        check("async reset strobes", {29'd0, stb()}, 0);
        check("async reset loaded", {31'd0, loaded}, 0);
        check("async reset core_reset_n", {31'd0, core_reset_n}, 0);
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("restart from HOLD", {31'd0, core_reset_n}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
